// File: rtl/lut_sweep_eval.sv
// lut_sweep_eval: run-time loadable N_IN-input truth table with point eval and exhaustive sweep.
// Define LUT_SWEEP_BACKPRESSURE_EN to add the sweep_ready port and consumer backpressure.
module lut_sweep_eval #(
    parameter int N_IN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic            cfg_bit,
    input  logic [N_IN-1:0] eval_in,
    output logic            eval_out,
    input  logic            start,
`ifdef LUT_SWEEP_BACKPRESSURE_EN
    input  logic            sweep_ready,
`endif
    output logic            busy,
    output logic            sweep_valid,
    output logic [N_IN-1:0] sweep_idx,
    output logic            sweep_val,
    output logic            done,
    output logic [N_IN:0]   ones_cnt
);

    localparam int LUT_BITS = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(LUT_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [LUT_BITS-1:0] lut_q;
    logic [N_IN-1:0]     idx_q;
    logic                rdy;
    logic                accept;
    logic                is_last;
    logic                cur_val;

`ifdef LUT_SWEEP_BACKPRESSURE_EN
    assign rdy = sweep_ready;
`else
    assign rdy = 1'b1;
`endif

    assign cur_val = lut_q[idx_q];
    assign accept  = (state == SWEEP) && rdy;
    assign is_last = (idx_q == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a sweep walks every index, then spends one cycle in DONE
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                if (accept && is_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; stream fields read zero when nothing is presented
    always_comb begin
        busy        = 1'b0;
        sweep_valid = 1'b0;
        done        = 1'b0;
        sweep_idx   = '0;
        sweep_val   = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
            end
            SWEEP: begin
                busy        = 1'b1;
                sweep_valid = 1'b1;
                sweep_idx   = idx_q;
                sweep_val   = cur_val;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Table load: shift in MSB-first, only while idle and not starting a sweep
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lut_q <= '0;
        end else if (cfg_we && (state == IDLE) && !start) begin
            lut_q <= {lut_q[LUT_BITS-2:0], cfg_bit};
        end
    end

    // Point evaluation sees the table as it was before any same-edge write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eval_out <= 1'b0;
        end else begin
            eval_out <= lut_q[eval_in];
        end
    end

    // Sweep index and minterm count; count holds after the sweep until restart
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q    <= '0;
            ones_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            idx_q    <= '0;
            ones_cnt <= '0;
        end else if (accept) begin
            ones_cnt <= ones_cnt + {{N_IN{1'b0}}, cur_val};
            if (!is_last) begin
                idx_q <= idx_q + N_IN'(1);
            end
        end
    end

endmodule

// File: tb/tb_lut_sweep_eval.sv
// tb_lut_sweep_eval: randomized checks of lut_sweep_eval against a write-history model.
// Covers N_IN=4 in depth plus N_IN=6 and N_IN=2 sweep timing/count.
module tb_lut_sweep_eval;

    localparam int N  = 4;
    localparam int LB = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_we, cfg_bit, start;
    logic [N-1:0] eval_in;
    logic         eval_out, busy, sweep_valid, sweep_val, done;
    logic [N-1:0] sweep_idx;
    logic [N:0]   ones_cnt;
`ifdef LUT_SWEEP_BACKPRESSURE_EN
    logic         sweep_ready;
`endif

    logic         cfg_we6, cfg_bit6, start6;
    logic [5:0]   eval_in6, sweep_idx6;
    logic         eval_out6, busy6, sweep_valid6, sweep_val6, done6;
    logic [6:0]   ones_cnt6;

    logic         cfg_we2, cfg_bit2, start2;
    logic [1:0]   eval_in2, sweep_idx2;
    logic         eval_out2, busy2, sweep_valid2, sweep_val2, done2;
    logic [2:0]   ones_cnt2;

    int errors = 0;
    int checks = 0;

    // every bit accepted by the table, oldest first
    bit hist[$];

    always #5 clk = ~clk;

    lut_sweep_eval #(.N_IN(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_bit     (cfg_bit),
        .eval_in     (eval_in),
        .eval_out    (eval_out),
        .start       (start),
`ifdef LUT_SWEEP_BACKPRESSURE_EN
        .sweep_ready (sweep_ready),
`endif
        .busy        (busy),
        .sweep_valid (sweep_valid),
        .sweep_idx   (sweep_idx),
        .sweep_val   (sweep_val),
        .done        (done),
        .ones_cnt    (ones_cnt)
    );

    lut_sweep_eval #(.N_IN(6)) dut6 (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we6),
        .cfg_bit     (cfg_bit6),
        .eval_in     (eval_in6),
        .eval_out    (eval_out6),
        .start       (start6),
`ifdef LUT_SWEEP_BACKPRESSURE_EN
        .sweep_ready (1'b1),
`endif
        .busy        (busy6),
        .sweep_valid (sweep_valid6),
        .sweep_idx   (sweep_idx6),
        .sweep_val   (sweep_val6),
        .done        (done6),
        .ones_cnt    (ones_cnt6)
    );

    lut_sweep_eval #(.N_IN(2)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we2),
        .cfg_bit     (cfg_bit2),
        .eval_in     (eval_in2),
        .eval_out    (eval_out2),
        .start       (start2),
`ifdef LUT_SWEEP_BACKPRESSURE_EN
        .sweep_ready (1'b1),
`endif
        .busy        (busy2),
        .sweep_valid (sweep_valid2),
        .sweep_idx   (sweep_idx2),
        .sweep_val   (sweep_val2),
        .done        (done2),
        .ones_cnt    (ones_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // minterm m holds the bit written m writes before the most recent one
    function automatic logic exp_val(input int m);
        int p;
        p = hist.size() - 1 - m;
        return (p >= 0) ? hist[p] : 1'b0;
    endfunction

    function automatic int exp_ones();
        int s = 0;
        for (int m = 0; m < LB; m++) s += int'(exp_val(m));
        return s;
    endfunction

    // one config write, with a random point evaluation on the same edge
    task automatic cfg_write(input logic b);
        logic pre;
        cfg_we  = 1'b1;
        cfg_bit = b;
        eval_in = N'($urandom);
        pre     = exp_val(int'(eval_in));
        tick();
        chk("eval_on_write", eval_out, pre);
        hist.push_back(b);
        cfg_we = 1'b0;
    endtask

    task automatic load_mask(input logic [LB-1:0] mask);
        for (int m = LB - 1; m >= 0; m--) cfg_write(mask[m]);
    endtask

    task automatic eval_point(input logic [N-1:0] v, input string tag);
        logic pre;
        eval_in = v;
        pre     = exp_val(int'(v));
        tick();
        chk(tag, eval_out, pre);
    endtask

    task automatic run_sweep(input int stall_at, input int stall_len,
                             input int inject_at, output logic [N:0] cnt_o);
        int   exp_cnt;
        logic pre;
        exp_cnt = 0;
        start   = 1'b1;
        eval_in = N'($urandom);
        pre     = exp_val(int'(eval_in));
        tick();
        chk("eval_at_start", eval_out, pre);
        start = 1'b0;
        for (int i = 0; i < LB; i++) begin
            chk("sw_valid", sweep_valid, 1);
            chk("sw_busy", busy, 1);
            chk("sw_idx", sweep_idx, i);
            chk("sw_val", sweep_val, exp_val(i));
            chk("sw_cnt", ones_cnt, exp_cnt);
            chk("sw_nodone", done, 0);
`ifdef LUT_SWEEP_BACKPRESSURE_EN
            if (i == stall_at) begin
                sweep_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    chk("stall_idx", sweep_idx, i);
                    chk("stall_val", sweep_val, exp_val(i));
                    chk("stall_cnt", ones_cnt, exp_cnt);
                    chk("stall_valid", sweep_valid, 1);
                end
                sweep_ready = 1'b1;
            end
`endif
            if (i == inject_at) begin
                start   = 1'b1;
                cfg_we  = 1'b1;
                cfg_bit = 1'b1;
            end
            eval_in = N'($urandom);
            pre     = exp_val(int'(eval_in));
            tick();
            chk("eval_in_sweep", eval_out, pre);
            start   = 1'b0;
            cfg_we  = 1'b0;
            exp_cnt += int'(exp_val(i));
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_valid", sweep_valid, 0);
        chk("done_idx0", sweep_idx, 0);
        chk("done_val0", sweep_val, 0);
        chk("done_cnt", ones_cnt, exp_cnt);
        tick();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_cnt", ones_cnt, exp_ones());
        cnt_o = ones_cnt;
    endtask

    initial begin
        logic [N:0] c1, c2;
        int         got;
        rst_n    = 1'b0;
        cfg_we   = 1'b0;
        cfg_bit  = 1'b0;
        start    = 1'b0;
        eval_in  = '0;
`ifdef LUT_SWEEP_BACKPRESSURE_EN
        sweep_ready = 1'b1;
`endif
        cfg_we6  = 1'b0; cfg_bit6 = 1'b0; start6 = 1'b0; eval_in6 = '0;
        cfg_we2  = 1'b0; cfg_bit2 = 1'b0; start2 = 1'b0; eval_in2 = '0;

        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", sweep_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", ones_cnt, 0);
        chk("rst_eval", eval_out, 0);
        chk("rst_idx", sweep_idx, 0);
        rst_n = 1'b1;

        // m(1,2,5,8,12,13)
        load_mask(16'h3126);
        eval_point(4'b1100, "eval_1100");
        chk("eval_1100_lit", eval_out, 1);
        eval_point(4'b0011, "eval_0011");
        chk("eval_0011_lit", eval_out, 0);
        run_sweep(-1, 0, -1, c1);
        chk("dir_ones", c1, 6);
`ifdef LUT_SWEEP_BACKPRESSURE_EN
        run_sweep(5, 3, -1, c2);
        chk("bp_ones", c2, 6);
`endif

        // start/cfg while busy must be ignored
        run_sweep(-1, 0, 7, c1);
        run_sweep(-1, 0, -1, c2);
        chk("rerun_same", c2, c1);

        // randomized tables, overlong loads, random stalls
        for (int r = 0; r < 6; r++) begin
            int nw;
            nw = LB + int'($urandom_range(0, 5));
            for (int w = 0; w < nw; w++) cfg_write(1'($urandom));
            for (int e = 0; e < 3; e++) eval_point(N'($urandom), "eval_rand");
            run_sweep(int'($urandom_range(0, LB - 1)),
                      int'($urandom_range(1, 4)), -1, c1);
            chk("rand_ones", c1, exp_ones());
        end

        // reset in the middle of a sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("mid_idx9", sweep_idx, 9);
        rst_n = 1'b0;
        tick();
        hist.delete();
        chk("mid_busy", busy, 0);
        chk("mid_valid", sweep_valid, 0);
        chk("mid_done", done, 0);
        chk("mid_cnt", ones_cnt, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mid_nodone", done, 0);
        end
        run_sweep(-1, 0, -1, c1);
        chk("post_rst_ones", c1, 0);

        // N_IN=6 all-ones table
        cfg_we6  = 1'b1;
        cfg_bit6 = 1'b1;
        repeat (64) tick();
        cfg_we6 = 1'b0;
        start6  = 1'b1;
        tick();
        start6 = 1'b0;
        got    = -1;
        for (int c = 1; c <= 100; c++) begin
            if (done6) begin
                got = c;
                break;
            end
            tick();
        end
        chk("n6_done_at", got, 65);
        chk("n6_ones", ones_cnt6, 64);
        tick();
        chk("n6_idle", busy6, 0);

        // N_IN=2 m(0,3): write order is m3..m0
        cfg_we2 = 1'b1;
        cfg_bit2 = 1'b1; tick();
        cfg_bit2 = 1'b0; tick();
        cfg_bit2 = 1'b0; tick();
        cfg_bit2 = 1'b1; tick();
        cfg_we2 = 1'b0;
        start2  = 1'b1;
        tick();
        start2 = 1'b0;
        got    = -1;
        for (int c = 1; c <= 20; c++) begin
            if (done2) begin
                got = c;
                break;
            end
            tick();
        end
        chk("n2_done_at", got, 5);
        chk("n2_ones", ones_cnt2, 2);
        tick();
        chk("n2_idle", busy2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lut_sweep_eval.md
Name: lut_sweep_eval

Overview:
- Programmable N-input single-output truth-table (LUT) block. It generalises the team's fixed 4-input minterm functions to any function of N_IN inputs, loaded at run time.
- Provides two services:
  - a registered point evaluation port;
  - a sequenced exhaustive sweep that streams every input combination with its result and counts the minterms.
- Sits beside the exercise functions as a reusable evaluator and self-check source for truth-table benches.

Parameters:
- N_IN, 4, number of function inputs; legal range 2..6. The table has LUT_BITS = 2**N_IN entries (derived locally, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- cfg_we  input  1  shift one configuration bit into the table
- cfg_bit  input  1  configuration bit value
- eval_in  input  N_IN  point-evaluation input vector; index = {x,y,w,z,...}, MSB first
- eval_out  output  1  registered table[eval_in]
- start  input  1  begin a sweep; sampled only in IDLE
- sweep_ready  input  1  consumer accepts the current sweep element (exists only with the optional feature)
- busy  output  1  high whenever state != IDLE
- sweep_valid  output  1  a sweep element is presented
- sweep_idx  output  N_IN  input combination being presented
- sweep_val  output  1  table[sweep_idx]
- done  output  1  one-cycle pulse after the last element is accepted
- ones_cnt  output  N_IN+1  number of 1 entries accepted in the current or last sweep

Behaviour:
- Reset: rst_n sampled low at a rising edge forces the following values. A reset mid-sweep aborts the sweep with no done pulse.
  - table = 0, state = IDLE, idx = 0;
  - eval_out, done, busy, sweep_valid = 0;
  - ones_cnt = 0.
- Config load: at an edge with cfg_we=1 and state==IDLE, table <= {table[LUT_BITS-2:0], cfg_bit}.
  - Bits are fed MSB first: the first bit is for minterm LUT_BITS-1, the last bit (the LUT_BITS-th write) is for minterm 0.
  - Writing more than LUT_BITS bits discards the oldest.
  - cfg_we is ignored while busy.
- Point evaluation: every edge, eval_out <= table[eval_in]. Latency is 1 cycle.
  - It operates in all states.
  - If cfg_we is applied at the same edge, eval_out uses the pre-write table.
- Sweep FSM:
  - IDLE: start=1 at an edge moves to SWEEP with idx <= 0 and ones_cnt <= 0. A simultaneous cfg_we is ignored.
  - SWEEP: sweep_valid=1, sweep_idx=idx, sweep_val=table[idx].
    - Element accepted = sweep_valid & sweep_ready. On acceptance, ones_cnt += sweep_val.
    - If idx != LUT_BITS-1, then idx++; otherwise go to DONE.
    - While the element is not accepted, sweep_idx and sweep_val stay stable.
  - DONE (1 cycle): done=1, busy=1, sweep_valid=0. Then go to IDLE.
  - start asserted while busy is ignored. A start held high re-triggers only once IDLE is re-entered.
- Timing with ready=1: start sampled at edge k, idx 0 visible after edge k, last index after edge k+LUT_BITS-1, done after edge k+LUT_BITS, busy low after edge k+LUT_BITS+1.
- Counting: ones_cnt reaches LUT_BITS for an all-ones table with no overflow, hence the width N_IN+1. It holds its final value in IDLE until the next start.
- Output defaults: sweep_idx reads 0 and sweep_val reads 0 when sweep_valid=0.

Optional Feature:
- LUT_SWEEP_BACKPRESSURE_EN defined: the sweep_ready port exists and acceptance follows the rule in Behaviour, so the sweep can stall indefinitely.
- Undefined: there is no sweep_ready port and ready is internally tied to 1. A sweep then always takes exactly LUT_BITS cycles plus 1 DONE cycle.

Test Plan:
- N_IN=4: load minterms m(1,2,5,8,12,13) with 16 cfg writes, then pulse start with ready=1 → 16 elements idx 0..15, sweep_val=1 exactly at 1,2,5,8,12,13; done after edge k+16; ones_cnt=6.
- After the above load, drive eval_in=4'b1100 then 4'b0011 → eval_out=1 then 0, each one cycle later. A cfg write on the same edge does not affect that cycle's eval_out.
- Backpressure (macro defined): drop sweep_ready low for 3 cycles at idx=5 → idx 5 held stable for those cycles, no count change; total sweep plus done = 20 cycles; ones_cnt unchanged vs ready=1.
- Assert rst_n=0 at idx=9 mid-sweep → next cycle busy=0, sweep_valid=0, done never pulses, ones_cnt=0. A sweep after reset with no reload gives ones_cnt=0.
- During a sweep, pulse start and cfg_we with cfg_bit=1 → no restart, table unchanged; a rerun reproduces an identical ones_cnt.
- N_IN=6, all-ones table (64 writes of 1) → 64 elements, ones_cnt=7'd64; N_IN=2 m(0,3) → ones_cnt=2, done after edge k+4.
